// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler: grants one requester at a time and drives the
// shared UART register port through data load, control write and status poll.
module uart_tx_sched #(
  parameter int unsigned NREQ      = 4,
  parameter logic [15:0] CTRL_BASE = 16'h0020,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [NREQ-1:0]     iReq,
  input  logic [8*NREQ-1:0]   iReqData,
  output logic [NREQ-1:0]     oGrant,
  output logic [NREQ-1:0]     oDone,
  output logic                oTimeout,
  output logic                oBusy,
  output logic [1:0]          oAddr,
  output logic [15:0]         oData,
  input  logic [15:0]         iData,
  output logic                oWrite,
  output logic                oEnable
);

  localparam int unsigned IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] CTRL_WORD = CTRL_BASE | 16'h0080;

  typedef enum logic [2:0] {IDLE, WDATA, WCTRL, POLL, DONE} stateT;

  stateT           rState, nState;
  logic [IW-1:0]   rIdx, nIdx, rPtr, nPtr;
  logic [7:0]      rByte, nByte;
  logic [15:0]     rCnt, nCnt;
  logic            rFlag, nFlag;
  logic [NREQ-1:0] nGrant, nDone;
  logic            nTimeout, nBusy, nWrite, nEnable;
  logic [1:0]      nAddr;
  logic [15:0]     nData;

  logic            found;
  logic [IW-1:0]   win, cand;
  logic            unusedData;

  assign unusedData = ^{iData[15:8], iData[6:0]};

  function automatic logic [IW-1:0] wrapIdx(input logic [31:0] v);
    return IW'(v % NREQ);
  endfunction

  // First active requester at or after rPtr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = wrapIdx(32'(rPtr) + 32'(i));
      if (!found && iReq[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next state and the registered values of every output
  always_comb begin
    nState   = rState;
    nIdx     = rIdx;
    nPtr     = rPtr;
    nByte    = rByte;
    nCnt     = rCnt;
    nFlag    = rFlag;
    nGrant   = '0;
    nDone    = '0;
    nTimeout = 1'b0;
    nBusy    = 1'b0;
    nWrite   = 1'b0;
    nEnable  = 1'b0;
    nAddr    = 2'd0;
    nData    = 16'd0;

    case (rState)
      IDLE: begin
        if (found) begin
          nIdx   = win;
          nByte  = iReqData[32'(win)*8 +: 8];
          nPtr   = wrapIdx(32'(win) + 32'd1);
          nState = WDATA;
        end
      end
      WDATA: nState = WCTRL;
      WCTRL: begin
        nCnt   = 16'd0;
        nFlag  = 1'b0;
        nState = POLL;
      end
      POLL: begin
        nCnt = (rCnt >= TIMEOUT) ? TIMEOUT : rCnt + 16'd1;
        // Poll index 0 may still see the previous send's idle status
        if ((rCnt != 16'd0) && !iData[7]) begin
          nState = DONE;
        end else if (rCnt >= TIMEOUT) begin
          nFlag  = 1'b1;
          nState = DONE;
        end
      end
      DONE:    nState = IDLE;
      default: nState = IDLE;
    endcase

    case (nState)
      WDATA: begin
        nEnable = 1'b1;
        nWrite  = 1'b1;
        nAddr   = 2'd1;
        nData   = {8'h00, nByte};
        nGrant  = NREQ'(1) << nIdx;
        nBusy   = 1'b1;
      end
      WCTRL: begin
        nEnable = 1'b1;
        nWrite  = 1'b1;
        nAddr   = 2'd0;
        nData   = CTRL_WORD;
        nGrant  = NREQ'(1) << nIdx;
        nBusy   = 1'b1;
      end
      POLL: begin
        nEnable = 1'b1;
        nGrant  = NREQ'(1) << nIdx;
        nBusy   = 1'b1;
      end
      DONE: begin
        nDone    = NREQ'(1) << nIdx;
        nTimeout = nFlag;
        nBusy    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rState   <= IDLE;
      rIdx     <= '0;
      rPtr     <= '0;
      rByte    <= 8'd0;
      rCnt     <= 16'd0;
      rFlag    <= 1'b0;
      oGrant   <= '0;
      oDone    <= '0;
      oTimeout <= 1'b0;
      oBusy    <= 1'b0;
      oWrite   <= 1'b0;
      oEnable  <= 1'b0;
      oAddr    <= 2'd0;
      oData    <= 16'd0;
    end else begin
      rState   <= nState;
      rIdx     <= nIdx;
      rPtr     <= nPtr;
      rByte    <= nByte;
      rCnt     <= nCnt;
      rFlag    <= nFlag;
      oGrant   <= nGrant;
      oDone    <= nDone;
      oTimeout <= nTimeout;
      oBusy    <= nBusy;
      oWrite   <= nWrite;
      oEnable  <= nEnable;
      oAddr    <= nAddr;
      oData    <= nData;
    end
  end

endmodule
